ext_obi_prog_demux: RTL and testbench
=====================================

Name: ext_obi_prog_demux

Overview:
- Parametrised successor to the static external-peripheral address map. Address rules live in runtime-programmable registers instead of elaboration-time constants.
- Demultiplexes one OBI master onto NSLAVE external slave ports using those rules.
- Tracks outstanding transactions so responses return in order.
- Unmapped accesses go to an internal error responder.
- Sits between the MCU external peripheral master port and the external peripherals.

Parameters:
NSLAVE, 3, number of slave ports and address rules (>=1)
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width (multiple of 8)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (>=1)
RST_RULES, all-zero, reset value per rule of {start, end, enable}; NSLAVE entries

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
m_req_i  in  1  master request
m_we_i  in  1  master write enable
m_be_i  in  DATA_WIDTH/8  byte enables
m_addr_i  in  ADDR_WIDTH  address
m_wdata_i  in  DATA_WIDTH  write data
m_gnt_o  out  1  grant
m_rvalid_o  out  1  response valid
m_rdata_o  out  DATA_WIDTH  read data
m_err_o  out  1  decode error, qualified by m_rvalid_o
s_req_o  out  NSLAVE  per-slave request
s_we_o / s_be_o / s_addr_o / s_wdata_o  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  broadcast copies of master fields
s_gnt_i  in  NSLAVE  per-slave grant
s_rvalid_i  in  NSLAVE  per-slave response valid
s_rdata_i  in  NSLAVE*DATA_WIDTH  per-slave read data, slave k at bits [k*DATA_WIDTH +: DATA_WIDTH]
cfg_req_i  in  1  config access strobe
cfg_we_i  in  1  config write
cfg_idx_i  in  max(1,$clog2(NSLAVE))  rule index
cfg_field_i  in  2  0=start, 1=end, 2=ctrl (bit0 enable), 3=global
cfg_wdata_i  in  32  config write data
cfg_rdata_o  out  32  config read data, valid 1 cycle after cfg_req_i

Behaviour:
- Reset is synchronous, active-low on rst_ni, single clock clk_i.
- Reset values:
  - rules = RST_RULES; lock = 0
  - outstanding count = 0; current target = NONE
  - m_gnt_o, m_rvalid_o, m_err_o, s_req_o = 0
  - m_rdata_o = 0; cfg_rdata_o = 0
- Decode (combinational on current rule registers):
  - Rule k matches when enabled and start_k <= m_addr_i < end_k.
  - A rule with end <= start never matches.
  - Overlapping matches: lowest index wins.
  - No match: target = ERR (pseudo-index NSLAVE).
- Issue permission: count == 0, or (decoded target == current target and count < MAX_OUTSTANDING).
- Request and grant:
  - s_req_o[t] = m_req_i & permitted, for t < NSLAVE.
  - m_gnt_o = permitted & (s_gnt_i[t] for a slave, 1 for ERR).
- On accept (m_req_i & m_gnt_o): count += 1; current target = t.
- Response routing:
  - m_rvalid_o = s_rvalid_i[current] when count > 0.
  - m_rdata_o is muxed from the current target.
  - Response decrements count.
  - Accept and response in the same cycle: count unchanged.
- ERR responder: rvalid exactly 1 cycle after accept, rdata = 0, m_err_o = 1; writes are discarded.
- s_rvalid_i from a non-current slave, or while count == 0: dropped, not forwarded.
- Count never exceeds MAX_OUTSTANDING; when the limit is reached the grant is withheld.
- Config writes:
  - Ignored while lock = 1.
  - Take effect for decode the next cycle.
  - Never alter the current target or count.
- Global field (field 3):
  - Write bit0 = 1 sets lock. Lock clears only on reset.
  - Read returns {err_cnt[15:0] or 0, 15'b0, lock}.
- Config reads return the register value registered 1 cycle later.
- cfg_idx_i >= NSLAVE: writes ignored, reads return 0.
- Reset mid-transaction: all state cleared; late slave responses are dropped.

Optional Feature:
- Macro: EXT_OBI_DEMUX_ERR_CNT_EN.
- Defined:
  - 16-bit saturating counter increments on each accepted ERR-target transaction.
  - Readable in global bits [31:16].
  - Global write with bit1 = 1 clears it; this is permitted even when locked.
- Undefined: counter absent; bits [31:16] read 0; bit1 has no effect.

Test Plan:
- Program rules 0:[0x20000000,0x20000010), 1:[0x20001000,0x20001100), 2:[0x20002000,0x20002100), all enabled. Read 0x20001004 with slave1 returning 0xCAFEF00D -> s_req_o=3'b010; m_rdata_o=0xCAFEF00D; m_err_o=0.
- Same map. Back-to-back reads to slave0, then a read to slave2, with slave0 rvalid delayed 3 cycles -> 2 slave0 accepts; slave2 request held (s_req_o[2]=0) until count returns to 0.
- Read 0x20005000 -> granted the same cycle; rvalid the next cycle with m_err_o=1, rdata=0. With EXT_OBI_DEMUX_ERR_CNT_EN, global read shows 0x0001_0000.
- Set rule 1 = rule 0 range, both enabled; access 0x20000004 -> slave0 selected. Disable rule 0 -> slave1 selected.
- Write global bit0=1, then write rule0 start=0 -> readback unchanged and lock=1. Reset -> rules equal RST_RULES, lock=0.
- Assert rst_ni=0 with 2 outstanding, then a slave rvalid after reset -> m_rvalid_o stays 0; count=0.

Source files
------------

// File: rtl/ext_obi_prog_demux.sv
// OBI 1-to-NSLAVE demultiplexer with runtime-programmable address rules and an internal error responder.
// Define EXT_OBI_DEMUX_ERR_CNT_EN to add a saturating decode-error counter in the global register.
module ext_obi_prog_demux #(
  parameter int unsigned NSLAVE          = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [NSLAVE*(2*ADDR_WIDTH+1)-1:0] RST_RULES = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           m_req_i,
  input  logic                           m_we_i,
  input  logic [DATA_WIDTH/8-1:0]        m_be_i,
  input  logic [ADDR_WIDTH-1:0]          m_addr_i,
  input  logic [DATA_WIDTH-1:0]          m_wdata_i,
  output logic                           m_gnt_o,
  output logic                           m_rvalid_o,
  output logic [DATA_WIDTH-1:0]          m_rdata_o,
  output logic                           m_err_o,
  output logic [NSLAVE-1:0]              s_req_o,
  output logic                           s_we_o,
  output logic [DATA_WIDTH/8-1:0]        s_be_o,
  output logic [ADDR_WIDTH-1:0]          s_addr_o,
  output logic [DATA_WIDTH-1:0]          s_wdata_o,
  input  logic [NSLAVE-1:0]              s_gnt_i,
  input  logic [NSLAVE-1:0]              s_rvalid_i,
  input  logic [NSLAVE*DATA_WIDTH-1:0]   s_rdata_i,
  input  logic                           cfg_req_i,
  input  logic                           cfg_we_i,
  input  logic [((NSLAVE > 1) ? $clog2(NSLAVE) : 1)-1:0] cfg_idx_i,
  input  logic [1:0]                     cfg_field_i,
  input  logic [31:0]                    cfg_wdata_i,
  output logic [31:0]                    cfg_rdata_o
);

  localparam int unsigned IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned TW = $clog2(NSLAVE + 2);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned RW = 2 * ADDR_WIDTH + 1;
  localparam logic [TW-1:0] TGT_ERR  = TW'(NSLAVE);
  localparam logic [TW-1:0] TGT_NONE = TW'(NSLAVE + 1);

  logic [ADDR_WIDTH-1:0] rule_start [NSLAVE];
  logic [ADDR_WIDTH-1:0] rule_end   [NSLAVE];
  logic [NSLAVE-1:0]     rule_en;
  logic                  lock;
  logic [CW-1:0]         count;
  logic [TW-1:0]         cur;
  logic                  err_pend;
  logic [15:0]           err_cnt;
  logic [31:0]           cfg_rdata_q;

  logic [TW-1:0]         dec;
  logic                  cnt_zero, permitted, slv_gnt, accept, rsp_valid, rsp, glob_wr;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic [31:0]           rd_word;

  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [31:0] d);
    logic [ADDR_WIDTH+31:0] w;
    w = {{ADDR_WIDTH{1'b0}}, d};
    return w[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] to_word(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH+31:0] w;
    w = {32'b0, a};
    return w[31:0];
  endfunction

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    dec = TGT_ERR;
    for (int k = int'(NSLAVE) - 1; k >= 0; k--) begin
      if (rule_en[k] && (m_addr_i >= rule_start[k]) && (m_addr_i < rule_end[k])) dec = TW'(k);
    end
  end

  assign cnt_zero  = (count == '0);
  assign permitted = rst_ni && (cnt_zero || ((dec == cur) && (count < CW'(MAX_OUTSTANDING))));

  always_comb begin
    s_req_o = '0;
    slv_gnt = 1'b1;
    for (int k = 0; k < int'(NSLAVE); k++) begin
      if (dec == TW'(k)) begin
        s_req_o[k] = m_req_i & permitted;
        slv_gnt    = s_gnt_i[k];
      end
    end
  end

  assign m_gnt_o   = permitted & slv_gnt;
  assign accept    = m_req_i & m_gnt_o;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;

  always_comb begin
    rsp_valid = (cur == TGT_ERR) ? err_pend : 1'b0;
    rdata_mux = '0;
    for (int k = 0; k < int'(NSLAVE); k++) begin
      if (cur == TW'(k)) begin
        rsp_valid = s_rvalid_i[k];
        rdata_mux = s_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Responses are only forwarded while something is outstanding to the current target.
  assign rsp        = rst_ni && !cnt_zero && rsp_valid;
  assign m_rvalid_o = rsp;
  assign m_err_o    = rsp && (cur == TGT_ERR);
  assign m_rdata_o  = rsp ? rdata_mux : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count    <= '0;
      cur      <= TGT_NONE;
      err_pend <= 1'b0;
    end else begin
      err_pend <= accept && (dec == TGT_ERR);
      if (accept && !rsp)      count <= count + CW'(1);
      else if (!accept && rsp) count <= count - CW'(1);
      if (accept) cur <= dec;
    end
  end

  assign glob_wr = cfg_req_i && cfg_we_i && (cfg_field_i == 2'd3);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock <= 1'b0;
      for (int k = 0; k < int'(NSLAVE); k++) begin
        rule_start[k] <= RST_RULES[k*RW+1+ADDR_WIDTH +: ADDR_WIDTH];
        rule_end[k]   <= RST_RULES[k*RW+1 +: ADDR_WIDTH];
        rule_en[k]    <= RST_RULES[k*RW];
      end
    end else begin
      if (glob_wr && cfg_wdata_i[0]) lock <= 1'b1;
      if (cfg_req_i && cfg_we_i && !lock && (cfg_field_i != 2'd3)) begin
        for (int k = 0; k < int'(NSLAVE); k++) begin
          if (cfg_idx_i == IW'(k)) begin
            case (cfg_field_i)
              2'd0:    rule_start[k] <= to_addr(cfg_wdata_i);
              2'd1:    rule_end[k]   <= to_addr(cfg_wdata_i);
              default: rule_en[k]    <= cfg_wdata_i[0];
            endcase
          end
        end
      end
    end
  end

`ifdef EXT_OBI_DEMUX_ERR_CNT_EN
  // Clearing is allowed even when locked so software can always acknowledge errors.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                                  err_cnt <= '0;
    else if (glob_wr && cfg_wdata_i[1])                           err_cnt <= '0;
    else if (accept && (dec == TGT_ERR) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
  end
`else
  assign err_cnt = '0;
`endif

  always_comb begin
    rd_word = '0;
    if (cfg_field_i == 2'd3) begin
      rd_word = {err_cnt, 15'b0, lock};
    end else begin
      for (int k = 0; k < int'(NSLAVE); k++) begin
        if (cfg_idx_i == IW'(k)) begin
          case (cfg_field_i)
            2'd0:    rd_word = to_word(rule_start[k]);
            2'd1:    rd_word = to_word(rule_end[k]);
            default: rd_word = {31'b0, rule_en[k]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                     cfg_rdata_q <= '0;
    else if (cfg_req_i && !cfg_we_i) cfg_rdata_q <= rd_word;
  end

  assign cfg_rdata_o = cfg_rdata_q;

endmodule

// File: tb/tb_ext_obi_prog_demux.sv
// Testbench for ext_obi_prog_demux: vector tables, directed corner sequences and a randomized
// phase against a queue-based transaction model.
module tb_ext_obi_prog_demux;
  localparam int NS   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni;
  logic             m_req, m_we;
  logic [DW/8-1:0]  m_be;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_gnt_o, m_rvalid_o, m_err_o;
  logic [DW-1:0]    m_rdata_o;
  logic [NS-1:0]    s_req_o;
  logic             s_we_o;
  logic [DW/8-1:0]  s_be_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic [NS-1:0]    s_gnt, s_rvalid;
  logic [NS*DW-1:0] s_rdata;
  logic             cfg_req, cfg_we;
  logic [1:0]       cfg_idx, cfg_field;
  logic [31:0]      cfg_wdata, cfg_rdata_o;

  ext_obi_prog_demux #(
    .NSLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the programmable state
  logic [31:0] r_start [NS];
  logic [31:0] r_end   [NS];
  bit          r_en    [NS];
  bit          m_lock;
  logic [15:0] m_errcnt;

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      r_start[k] = '0; r_end[k] = '0; r_en[k] = 1'b0;
    end
    m_lock = 1'b0;
    m_errcnt = '0;
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if (r_en[k] && a >= r_start[k] && a < r_end[k]) return k;
    return NS;
  endfunction

  function automatic logic [31:0] exp_glob();
`ifdef EXT_OBI_DEMUX_ERR_CNT_EN
    return {m_errcnt, 15'b0, m_lock};
`else
    return {31'b0, m_lock};
`endif
  endfunction

  task automatic cfg_write(input int idx, input int field, input logic [31:0] d);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_field = field[1:0]; cfg_wdata = d;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
    if (field == 3) begin
      if (d[0]) m_lock = 1'b1;
      if (d[1]) m_errcnt = '0;
    end else if (!m_lock && idx < NS) begin
      case (field)
        0: r_start[idx] = d;
        1: r_end[idx]   = d;
        default: r_en[idx] = d[0];
      endcase
    end
  endtask

  task automatic cfg_read(input int idx, input int field, output logic [31:0] d);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = idx[1:0]; cfg_field = field[1:0];
    tick();
    cfg_req = 1'b0;
    d = cfg_rdata_o;
  endtask

  // Randomized traffic: model keeps accepted transactions in order with their response cycle
  typedef struct { int tgt; logic [31:0] data; int due; } txn_t;
  txn_t q[$];
  int   cur_m = NS + 1;
  int   cyc = 0;

  function automatic logic [31:0] rand_addr();
    logic [31:0] b [6];
    b = '{32'h2000_0010, 32'h1FFF_FFFF, 32'h2000_10FF, 32'h2000_1100, 32'h2000_20FF, 32'h2000_2100};
    case ($urandom_range(0, 5))
      0:       return 32'h2000_0000 + $urandom_range(0, 15);
      1, 4:    return 32'h2000_1000 + $urandom_range(0, 255);
      2:       return 32'h2000_2000 + $urandom_range(0, 255);
      3:       return b[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_cycle(input bit allow);
    int t;
    bit perm, egnt, erv, eerr;
    logic [NS-1:0] esreq;
    logic [31:0] erd;
    txn_t n;
    m_req   = allow && ($urandom_range(0, 3) != 0);
    m_addr  = rand_addr();
    m_we    = 1'($urandom_range(0, 1));
    m_wdata = $urandom;
    m_be    = 4'($urandom);
    s_gnt   = NS'($urandom);
    for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = $urandom;
    s_rvalid = '0;
    if (q.size() > 0 && q[0].tgt < NS && q[0].due <= cyc) begin
      s_rvalid[q[0].tgt] = 1'b1;
      s_rdata[q[0].tgt*DW +: DW] = q[0].data;
    end
    for (int k = 0; k < NS; k++)
      if ((q.size() == 0 || q[0].tgt != k) && $urandom_range(0, 7) == 0) s_rvalid[k] = 1'b1;
    #1;
    t = ref_decode(m_addr);
    perm = (q.size() == 0) || (t == cur_m && q.size() < MAXO);
    esreq = '0;
    if (m_req && perm && t < NS) esreq[t] = 1'b1;
    if (t < NS) egnt = perm && s_gnt[t];
    else        egnt = perm;
    erv = 1'b0; erd = '0; eerr = 1'b0;
    if (q.size() > 0) begin
      if (q[0].tgt == NS) begin erv = (cyc >= q[0].due); eerr = 1'b1; end
      else begin erv = (q[0].due <= cyc); erd = q[0].data; end
    end
    chk("rnd_gnt",    32'(m_gnt_o),    32'(egnt));
    chk("rnd_sreq",   32'(s_req_o),    32'(esreq));
    chk("rnd_rvalid", 32'(m_rvalid_o), 32'(erv));
    chk("rnd_saddr",  s_addr_o, m_addr);
    chk("rnd_swdata", s_wdata_o, m_wdata);
    if (erv) begin
      chk("rnd_rdata", m_rdata_o, erd);
      chk("rnd_err",   32'(m_err_o), 32'(eerr));
      void'(q.pop_front());
    end
    if (m_req && egnt) begin
      n.tgt  = t;
      n.data = $urandom;
      n.due  = (t == NS) ? cyc + 1 : cyc + 1 + int'($urandom_range(0, 3));
      if (q.size() > 0 && n.due <= q[$].due) n.due = q[$].due + 1;
      q.push_back(n);
      cur_m = t;
      if (t == NS && m_errcnt != 16'hFFFF) m_errcnt++;
    end
    tick();
    cyc++;
  endtask

  typedef struct { int idx; int field; logic [31:0] exp; } cfgvec_t;
  typedef struct { logic [31:0] addr; logic [NS-1:0] sreq; bit gnt; } decvec_t;
  cfgvec_t cv [11];
  decvec_t dv [11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    cv = '{
      '{0, 0, 32'h2000_0000}, '{0, 1, 32'h2000_0010}, '{0, 2, 32'h1},
      '{1, 0, 32'h2000_1000}, '{1, 1, 32'h2000_1100}, '{1, 2, 32'h1},
      '{2, 0, 32'h2000_2000}, '{2, 1, 32'h2000_2100}, '{2, 2, 32'h1},
      '{3, 0, 32'h0},         '{0, 3, 32'h0}
    };
    dv = '{
      '{32'h2000_0000, 3'b001, 1'b0}, '{32'h2000_000F, 3'b001, 1'b0}, '{32'h2000_0010, 3'b000, 1'b1},
      '{32'h2000_0FFF, 3'b000, 1'b1}, '{32'h2000_1000, 3'b010, 1'b0}, '{32'h2000_10FF, 3'b010, 1'b0},
      '{32'h2000_1100, 3'b000, 1'b1}, '{32'h2000_2000, 3'b100, 1'b0}, '{32'h2000_20FF, 3'b100, 1'b0},
      '{32'h1FFF_FFFF, 3'b000, 1'b1}, '{32'h0000_0000, 3'b000, 1'b1}
    };
    model_reset();

    rst_ni = 1'b0; m_req = 1'b1; m_we = 1'b0; m_be = '1; m_addr = '0; m_wdata = '0;
    s_gnt = '1; s_rvalid = '1; s_rdata = '1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    tick(); tick();
    chk("rst_gnt",    32'(m_gnt_o),    32'h0);
    chk("rst_sreq",   32'(s_req_o),    32'h0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    chk("rst_err",    32'(m_err_o),    32'h0);
    chk("rst_rdata",  m_rdata_o,       32'h0);
    chk("rst_cfgrd",  cfg_rdata_o,     32'h0);
    rst_ni = 1'b1; m_req = 1'b0; s_gnt = '0; s_rvalid = '0; s_rdata = '0;
    tick();
    cfg_read(0, 0, rd); chk("rst_rule0_start", rd, 32'h0);
    cfg_read(2, 2, rd); chk("rst_rule2_en", rd, 32'h0);

    cfg_write(0, 0, 32'h2000_0000); cfg_write(0, 1, 32'h2000_0010); cfg_write(0, 2, 32'h1);
    cfg_write(1, 0, 32'h2000_1000); cfg_write(1, 1, 32'h2000_1100); cfg_write(1, 2, 32'h1);
    cfg_write(2, 0, 32'h2000_2000); cfg_write(2, 1, 32'h2000_2100); cfg_write(2, 2, 32'h1);
    cfg_write(3, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 11; i++) begin
      cfg_read(cv[i].idx, cv[i].field, rd);
      chk($sformatf("cfg_rb_%0d_%0d", cv[i].idx, cv[i].field), rd, cv[i].exp);
    end

    for (int i = 0; i < 11; i++) begin
      m_addr = dv[i].addr; m_req = 1'b1;
      #1;
      chk($sformatf("dec_sreq_%08h", dv[i].addr), 32'(s_req_o), 32'(dv[i].sreq));
      chk($sformatf("dec_gnt_%08h", dv[i].addr),  32'(m_gnt_o), 32'(dv[i].gnt));
      m_req = 1'b0;
      tick();
    end

    // Single read to slave1
    m_addr = 32'h2000_1004; m_req = 1'b1; s_gnt = 3'b010;
    #1;
    chk("rd1_sreq", 32'(s_req_o), 32'b010);
    chk("rd1_gnt",  32'(m_gnt_o), 32'h1);
    tick();
    m_req = 1'b0; s_gnt = '0; s_rvalid = 3'b010; s_rdata[63:32] = 32'hCAFE_F00D;
    #1;
    chk("rd1_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("rd1_rdata",  m_rdata_o, 32'hCAFE_F00D);
    chk("rd1_err",    32'(m_err_o), 32'h0);
    tick();
    s_rvalid = '0;
    #1;
    chk("rd1_rvalid_done", 32'(m_rvalid_o), 32'h0);

    // Two outstanding to slave0, slave2 must wait for the count to drain
    m_addr = 32'h2000_0000; m_req = 1'b1; s_gnt = 3'b001;
    #1; chk("b2b_gnt0", 32'(m_gnt_o), 32'h1);
    tick();
    #1; chk("b2b_gnt1", 32'(m_gnt_o), 32'h1);
    tick();
    #1;
    chk("b2b_limit_gnt",  32'(m_gnt_o), 32'h0);
    chk("b2b_limit_sreq", 32'(s_req_o), 32'h0);
    m_addr = 32'h2000_2040; s_gnt = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_sreq2", 32'(s_req_o), 32'h0);
      chk("hold_gnt",   32'(m_gnt_o), 32'h0);
      tick();
    end
    s_rvalid = 3'b001; s_rdata[31:0] = 32'h1111_0001;
    #1;
    chk("b2b_rsp0_valid", 32'(m_rvalid_o), 32'h1);
    chk("b2b_rsp0_data",  m_rdata_o, 32'h1111_0001);
    chk("b2b_rsp0_sreq",  32'(s_req_o), 32'h0);
    tick();
    s_rdata[31:0] = 32'h1111_0002;
    #1;
    chk("b2b_rsp1_valid", 32'(m_rvalid_o), 32'h1);
    chk("b2b_rsp1_data",  m_rdata_o, 32'h1111_0002);
    chk("b2b_rsp1_sreq",  32'(s_req_o), 32'h0);
    tick();
    s_rvalid = '0;
    #1;
    chk("sw_sreq2", 32'(s_req_o), 32'b100);
    chk("sw_gnt",   32'(m_gnt_o), 32'h1);
    tick();
    m_req = 1'b0; s_gnt = '0; s_rvalid = 3'b100; s_rdata[95:64] = 32'h2222_0003;
    #1;
    chk("sw_rsp_valid", 32'(m_rvalid_o), 32'h1);
    chk("sw_rsp_data",  m_rdata_o, 32'h2222_0003);
    tick();
    s_rvalid = '0;

    // Unmapped access goes to the error responder
    m_addr = 32'h2000_5000; m_req = 1'b1;
    #1;
    chk("err_gnt",  32'(m_gnt_o), 32'h1);
    chk("err_sreq", 32'(s_req_o), 32'h0);
    tick();
    m_req = 1'b0; m_errcnt++;
    #1;
    chk("err_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("err_flag",   32'(m_err_o), 32'h1);
    chk("err_rdata",  m_rdata_o, 32'h0);
    tick();
    #1;
    chk("err_rvalid_once", 32'(m_rvalid_o), 32'h0);
    cfg_read(0, 3, rd); chk("glob_errcnt", rd, exp_glob());

    // Overlap priority, disable, and an empty rule
    cfg_write(1, 0, 32'h2000_0000); cfg_write(1, 1, 32'h2000_0010);
    m_addr = 32'h2000_0004; m_req = 1'b1;
    #1; chk("ovl_low", 32'(s_req_o), 32'b001);
    m_req = 1'b0; tick();
    cfg_write(0, 2, 32'h0);
    m_req = 1'b1;
    #1; chk("ovl_dis", 32'(s_req_o), 32'b010);
    m_req = 1'b0; tick();
    cfg_write(2, 1, 32'h2000_2000);
    m_addr = 32'h2000_2000; m_req = 1'b1;
    #1;
    chk("empty_rule_sreq", 32'(s_req_o), 32'h0);
    chk("empty_rule_gnt",  32'(m_gnt_o), 32'h1);
    m_req = 1'b0; tick();
    cfg_write(0, 2, 32'h1); cfg_write(1, 0, 32'h2000_1000);
    cfg_write(1, 1, 32'h2000_1100); cfg_write(2, 1, 32'h2000_2100);
    cfg_write(0, 3, 32'h2);
    cfg_read(0, 3, rd); chk("glob_clear", rd, exp_glob());

    for (int i = 0; i < 500; i++) rand_cycle(1'b1);
    for (int i = 0; i < 30 && q.size() > 0; i++) rand_cycle(1'b0);
    m_req = 1'b0; s_gnt = '0; s_rvalid = '0;
    tick();
    cfg_read(0, 3, rd); chk("rnd_glob", rd, exp_glob());

    // Lock
    cfg_write(0, 3, 32'h1);
    cfg_write(0, 0, 32'h0);
    cfg_read(0, 0, rd); chk("lock_rule0_start", rd, 32'h2000_0000);
    cfg_read(0, 3, rd); chk("lock_glob", rd, exp_glob());
    cfg_write(0, 3, 32'h2);
    cfg_read(0, 3, rd); chk("lock_clear_cnt", rd, exp_glob());

    // Reset with two transactions outstanding
    m_addr = 32'h2000_1010; m_req = 1'b1; s_gnt = 3'b010;
    #1; chk("mid_gnt0", 32'(m_gnt_o), 32'h1);
    tick();
    #1; chk("mid_gnt1", 32'(m_gnt_o), 32'h1);
    tick();
    rst_ni = 1'b0; m_req = 1'b0; s_gnt = '0;
    tick();
    model_reset();
    s_rvalid = 3'b010; s_rdata[63:32] = 32'h5A5A_5A5A;
    #1; chk("in_rst_rvalid", 32'(m_rvalid_o), 32'h0);
    rst_ni = 1'b1;
    #1; chk("post_rst_rvalid", 32'(m_rvalid_o), 32'h0);
    tick();
    s_rvalid = '0;
    cfg_read(1, 0, rd); chk("post_rst_rule1", rd, 32'h0);
    cfg_read(0, 3, rd); chk("post_rst_glob", rd, exp_glob());
    m_addr = 32'h2000_1010; m_req = 1'b1;
    #1;
    chk("post_rst_gnt",  32'(m_gnt_o), 32'h1);
    chk("post_rst_sreq", 32'(s_req_o), 32'h0);
    m_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
